// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of the write-back scheduler's producer, issue, read-port and register-file write signals.
// master = execute/issue side and testbench, slave = scheduler.
interface regfile_wb_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue_ready;

  logic [ADDR_W-1:0] rd_addra;
  logic [ADDR_W-1:0] rd_addrb;
  logic              busy_a;
  logic              busy_b;

  logic              enc;
  logic [ADDR_W-1:0] addrc;
  logic [DATA_W-1:0] datac;
  logic [ADDR_W:0]   pending;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    output issue_valid, issue_addr,
    input  issue_ready,
    output rd_addra, rd_addrb,
    input  busy_a, busy_b,
    input  enc, addrc, datac, pending
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    input  issue_valid, issue_addr,
    output issue_ready,
    input  rd_addra, rd_addrb,
    output busy_a, busy_b,
    output enc, addrc, datac, pending
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the register-file write port (ALU vs load) plus a
// per-register pending-write scoreboard used by issue to stall on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  regfile_wb_scheduler_if.slave bus
);

  typedef enum logic {
    PTR_ALU = 1'b0,
    PTR_MEM = 1'b1
  } ptr_e;

  ptr_e              r_ptr;
  logic [NREGS-1:0]  r_busy;
  logic [ADDR_W:0]   r_pending;
  logic              r_enc;
  logic [ADDR_W-1:0] r_addrc;
  logic [DATA_W-1:0] r_datac;

  logic              w_grant_alu;
  logic              w_grant_mem;
  logic              w_issue_ready;
  logic              w_issue_fire;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_clr;
  logic [NREGS-1:0]  w_busy_next;
  logic [ADDR_W:0]   w_pending_next;

  // A lone requester always wins; the pointer only breaks ties.
  assign w_grant_alu = i_rst_n & bus.alu_valid & (~bus.mem_valid | (r_ptr == PTR_ALU));
  assign w_grant_mem = i_rst_n & bus.mem_valid & (~bus.alu_valid | (r_ptr == PTR_MEM));

  // A register still being cleared this cycle is reported busy, so WAW waits one more cycle.
  assign w_issue_ready = i_rst_n & ~r_busy[bus.issue_addr];
  assign w_issue_fire  = bus.issue_valid & w_issue_ready;

  assign bus.alu_ready   = w_grant_alu;
  assign bus.mem_ready   = w_grant_mem;
  assign bus.issue_ready = w_issue_ready;
  assign bus.busy_a      = r_busy[bus.rd_addra];
  assign bus.busy_b      = r_busy[bus.rd_addrb];
  assign bus.enc         = r_enc;
  assign bus.addrc       = r_addrc;
  assign bus.datac       = r_datac;
  assign bus.pending     = r_pending;

  // Set wins over clear on the same bit: a fresh reservation outlives an unrelated write.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      assign w_set[gi]       = w_issue_fire & (bus.issue_addr == ADDR_W'(gi));
      assign w_clr[gi]       = r_enc & (r_addrc == ADDR_W'(gi));
      assign w_busy_next[gi] = w_set[gi] | (r_busy[gi] & ~w_clr[gi]);
    end
  endgenerate

  always_comb begin
    w_pending_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_pending_next = w_pending_next + (ADDR_W+1)'(w_busy_next[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr     <= PTR_ALU;
      r_busy    <= '0;
      r_pending <= '0;
      r_enc     <= 1'b0;
      r_addrc   <= '0;
      r_datac   <= '0;
    end else begin
      r_busy    <= w_busy_next;
      r_pending <= w_pending_next;
      r_enc     <= w_grant_alu | w_grant_mem;
      if (w_grant_alu) begin
        r_addrc <= bus.alu_addr;
        r_datac <= bus.alu_data;
        r_ptr   <= PTR_MEM;
      end else if (w_grant_mem) begin
        r_addrc <= bus.mem_addr;
        r_datac <= bus.mem_data;
        r_ptr   <= PTR_ALU;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: a reference model predicts handshakes, busy flags and the write stream;
// a separate monitor checks each register-file write against the expected-write queue.
module tb_regfile_wb_scheduler;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  regfile_wb_scheduler #(.DATA_W(DW), .ADDR_W(AW), .NREGS(NR)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  // Reference model state: which registers await a write, who has tie priority,
  // and which register is being written during the current cycle.
  bit  m_busy[NR];
  bit  m_mem_prio = 1'b0;
  bit  m_wb_now = 1'b0;
  int  m_wb_addr = 0;
  bit  alu_fire = 1'b0;
  bit  mem_fire = 1'b0;
  bit  e_alu, e_mem, e_iss;
  int  cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: evaluate expectations mid-cycle, then advance to the next cycle.
  initial begin
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      e_alu = rst_n && bus.alu_valid && (!bus.mem_valid || !m_mem_prio);
      e_mem = rst_n && bus.mem_valid && (!bus.alu_valid || m_mem_prio);
      e_iss = rst_n && !m_busy[bus.issue_addr];
      cnt = 0;
      foreach (m_busy[i]) cnt += int'(m_busy[i]);
      chk("alu_ready", bus.alu_ready, e_alu);
      chk("mem_ready", bus.mem_ready, e_mem);
      chk("issue_ready", bus.issue_ready, e_iss);
      chk("busy_a", bus.busy_a, m_busy[bus.rd_addra]);
      chk("busy_b", bus.busy_b, m_busy[bus.rd_addrb]);
      chk("pending", bus.pending, cnt);
      if (!rst_n) begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_mem_prio = 1'b0;
        m_wb_now = 1'b0;
        exp_q.delete();
      end else begin
        if (m_wb_now) m_busy[m_wb_addr] = 1'b0;
        if (bus.issue_valid && e_iss) m_busy[bus.issue_addr] = 1'b1;
        m_wb_now = 1'b0;
        if (e_alu) begin
          exp_q.push_back('{a: bus.alu_addr, d: bus.alu_data});
          m_wb_now = 1'b1;
          m_wb_addr = int'(bus.alu_addr);
          m_mem_prio = 1'b1;
        end else if (e_mem) begin
          exp_q.push_back('{a: bus.mem_addr, d: bus.mem_data});
          m_wb_now = 1'b1;
          m_wb_addr = int'(bus.mem_addr);
          m_mem_prio = 1'b0;
        end
      end
      alu_fire = e_alu;
      mem_fire = e_mem;
    end
  end

  // Monitor: every cycle the write port must match the oldest expected write (or be idle).
  initial begin
    wr_t w;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("enc", bus.enc, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (bus.enc === 1'b1) begin
          chk("addrc", bus.addrc, w.a);
          chk("datac", bus.datac, w.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  initial begin
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'h1111_0001;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 32'h2222_0002;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
    bus.rd_addra = 5'd5; bus.rd_addrb = 5'd9;

    // Reset with every valid high, then release with an idle bus.
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_enc", bus.enc, 1'b0);
    chk("reset_addrc", bus.addrc, 0);
    chk("reset_datac", bus.datac, 0);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    chk("post_reset_issue_ready", bus.issue_ready, 1'b1);

    // Single ALU write to register 5.
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd5;
    tick();
    bus.issue_valid = 1'b0;
    tick();
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    tick(); tick(); tick();

    // Contention straight out of reset: ALU, MEM, ALU, MEM.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'hA000_0001;
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd2; bus.mem_data = 32'hB000_0002;
    for (int i = 0; i < 4; i++) tick();
    idle_inputs();
    tick(); tick();

    // WAW stall on register 9, then a same-cycle clear of 9 and reservation of 10.
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
    tick();
    tick(); tick();
    bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h0909_0909;
    tick();
    bus.mem_valid = 1'b0;
    bus.issue_addr = 5'd10;
    tick();
    bus.issue_addr = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    tick();

    // Full scoreboard: reserve every register, then drain them through the load path.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < NR; a++) begin
      bus.issue_valid = 1'b1; bus.issue_addr = AW'(a);
      tick();
    end
    bus.issue_valid = 1'b0;
    tick();
    chk("full_pending", bus.pending, NR);
    for (int a = 0; a < NR; a++) begin
      bus.mem_valid = 1'b1; bus.mem_addr = AW'(a); bus.mem_data = $urandom;
      tick();
    end
    bus.mem_valid = 1'b0;
    tick(); tick();
    chk("drained_pending", bus.pending, 0);

    // Reset in the cycle after an ALU grant drops any further write.
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd3;
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h3333_3333;
    tick();
    bus.alu_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // Randomized traffic with held requests, hazards on a small register window, rare resets.
    for (int c = 0; c < 3000; c++) begin
      if (!bus.alu_valid || alu_fire) begin
        bus.alu_valid = ($urandom_range(0, 2) != 0);
        bus.alu_addr = AW'($urandom_range(0, 7));
        bus.alu_data = $urandom;
      end
      if (!bus.mem_valid || mem_fire) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_addr = AW'($urandom_range(0, 7));
        bus.mem_data = $urandom;
      end
      bus.issue_valid = ($urandom_range(0, 1) != 0);
      bus.issue_addr = AW'($urandom_range(0, 9));
      bus.rd_addra = AW'($urandom_range(0, 9));
      bus.rd_addrb = AW'($urandom_range(0, 9));
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    tick(); tick(); tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler for the 32×32 register file. Shares the single write port (enc/addrc/datac) between two producers (ALU and memory-load paths) using round-robin arbitration. Keeps a per-register pending-write scoreboard so the issue stage can stall on RAW/WAW hazards against read ports A and B. Sits between the execute/memory stages and the register file's write port.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NREGS, 32, number of registers (2**ADDR_W)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low; sampled on clock rising edge
- alu_valid  in  1  ALU write-back request
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  load write-back request
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle
- issue_valid  in  1  issue stage reserves a destination register
- issue_addr  in  ADDR_W  register being reserved
- issue_ready  out  1  reservation accepted this cycle
- rd_addra, rd_addrb  in  ADDR_W  addresses being read on ports A/B
- busy_a, busy_b  out  1  pending write exists for rd_addra/rd_addrb
- enc  out  1  register-file write enable (registered)
- addrc  out  ADDR_W  register-file write address (registered)
- datac  out  DATA_W  register-file write data (registered)
- pending  out  ADDR_W+1  number of set scoreboard bits

## Operation
- Handshake: a transfer occurs in a cycle when valid && ready. Producers hold valid/addr/data stable until accepted.
- Arbitration: at most one grant per cycle. If only one producer is valid, it is granted. If both are valid, the producer named by the priority pointer is granted. After any grant, the pointer moves to the other producer. With no grant, the pointer is unchanged. The reset pointer value is ALU.
- alu_ready and mem_ready are combinational from the valids and the pointer. At most one is high. Both are 0 while reset is low.
- Write stage: a granted request is registered into addrc/datac with enc=1 in the next cycle. In a cycle with no grant, the next enc=0 and addrc/datac hold their values.
- Scoreboard: busy[NREGS-1:0].
  - Set: busy[issue_addr] is set on issue_valid && issue_ready.
  - Clear: busy[addrc] is cleared in any cycle where enc=1 (the clear takes effect at the same edge the register file writes).
  - Set and clear on different addresses in the same cycle: both take effect.
- issue_ready = !busy[issue_addr]. A WAW reservation stalls until the older write clears. This holds even when that register is being cleared this cycle.
- Scoreboard is not consulted on write-back. A write to a non-busy register is still performed, and busy is unaffected.
- busy_a = busy[rd_addra] and busy_b = busy[rd_addrb], combinational from the current vector.
- pending = popcount(busy), registered alongside busy. Range 0..NREGS.
- Reset (reset==0 at an edge): enc=0, addrc=0, datac=0, busy=0, pending=0, pointer=ALU. Requests in flight are dropped. A reset mid-operation discards any registered write (enc forced 0 at that edge).

## Timing
- Grant in cycle N → enc=1 with the granted addr/data in cycle N+1 → register file writes at the end of N+1.
- busy bit for that address reads 0 from cycle N+2. The register file holds the new value from N+2 as well, so the stall releases exactly when the data is readable.
- Reservation accepted in cycle N → busy_a/busy_b reflect it from cycle N+1.
- Back-to-back grants sustain one write per cycle. Under continuous contention the two producers alternate ALU, MEM, ALU, …
- No combinational path from any input to enc/addrc/datac/pending.

## Test plan
- Reset: hold reset=0 for 2 cycles with all valids high → enc=0, addrc=0, datac=0, pending=0, alu_ready=mem_ready=issue_ready=0. Release reset → issue_ready=1 for issue_addr=7.
- Single ALU write: issue addr 5 (cycle 0) → busy_a=1 with rd_addra=5 from cycle 1. Apply alu_valid, addr 5, data 0xDEADBEEF in cycle 2 → alu_ready=1 in cycle 2; enc=1, addrc=5, datac=0xDEADBEEF in cycle 3; busy_a=0 and pending=0 in cycle 4.
- Contention: alu_valid and mem_valid held high for 4 cycles (alu addr 1, mem addr 2) → after reset, grants go ALU, MEM, ALU, MEM, and addrc goes 1, 2, 1, 2 one cycle later.
- WAW stall: register 9 busy; issue_valid with issue_addr=9 → issue_ready=0 until the write to 9 shows enc=1. issue_ready=1 the cycle after. In the same cycle as the clear, an issue to addr 10 is accepted and both updates land (pending unchanged).
- Full scoreboard: reserve addresses 0..31 on consecutive cycles → pending=32. Write back all 32 via MEM → pending returns to 0, one per cycle.
- Reset mid-operation: reset=0 in the cycle after an ALU grant → enc=0 at the next edge, busy cleared, and no write appears afterward.
